// File: rtl/postfix_eval_engine.sv
// postfix_eval_engine: fetches a postfix token stream from memory, evaluates it
// on an internal operand stack with signed W-bit arithmetic, and reports the
// result or the first error encountered.
module postfix_eval_engine #(
  parameter int W      = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] token_count,
  input  logic [W-1:0]      rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      result,
  output logic              error,
  output logic [2:0]        err_code
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_FINAL, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    E_NONE  = 3'd0,
    E_UNDER = 3'd1,
    E_OVER  = 3'd2,
    E_DIV0  = 3'd3,
    E_OPC   = 3'd4,
    E_DEPTH = 3'd5
  } err_e;

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_wcnt;
  logic [W-1:0]      r_tok;
  logic [W-1:0]      r_stk [DEPTH];
  logic [SPW-1:0]    r_sp;
  logic [W-1:0]      r_result;
  logic              r_error;
  logic [2:0]        r_err_code;

  logic              w_is_op;
  logic [2:0]        w_opc;
  logic [W-1:0]      w_operand;
  logic [IW-1:0]     w_ti;
  logic [IW-1:0]     w_si;
  logic [IW-1:0]     w_pi;
  logic [W-1:0]      w_a;
  logic [W-1:0]      w_b;
  logic [W-1:0]      w_bsafe;
  logic [W-1:0]      w_quot;
  logic [W-1:0]      w_alu;
  err_e              w_ex_err;
  logic [ADDR_W-1:0] w_idx_nx;
  logic              w_last;
  logic              w_wait_end;

  assign w_is_op    = r_tok[W-1];
  assign w_opc      = r_tok[2:0];
  assign w_operand  = {1'b0, r_tok[W-2:0]};
  assign w_ti       = IW'(r_sp - SPW'(1));
  assign w_si       = IW'(r_sp - SPW'(2));
  assign w_pi       = IW'(r_sp);
  assign w_a        = r_stk[w_si];
  assign w_b        = r_stk[w_ti];
  assign w_idx_nx   = r_idx + ADDR_W'(1);
  assign w_last     = (w_idx_nx == r_cnt);
  assign w_wait_end = (r_wcnt == 2'(RD_LAT - 1));

  // ALU and EXEC error classification for the registered token
  always_comb begin
    w_bsafe  = (w_b == '0) ? W'(1) : w_b;
    // x / -1 is negation; this sidesteps the MIN_INT / -1 overflow case
    if (w_b == '1) w_quot = '0 - w_a;
    else           w_quot = $signed(w_a) / $signed(w_bsafe);
    case (w_opc)
      3'd1:    w_alu = w_a + w_b;
      3'd2:    w_alu = w_a - w_b;
      3'd3:    w_alu = w_a * w_b;
      3'd5:    w_alu = w_quot;
      default: w_alu = '0;
    endcase
    w_ex_err = E_NONE;
    if (!w_is_op) begin
      if (r_sp == SPW'(DEPTH)) w_ex_err = E_OVER;
    end else if (r_sp < SPW'(2)) begin
      w_ex_err = E_UNDER;
    end else begin
      case (w_opc)
        3'd1, 3'd2, 3'd3: w_ex_err = E_NONE;
        3'd5:             w_ex_err = (w_b == '0) ? E_DIV0 : E_NONE;
        default:          w_ex_err = E_OPC;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (token_count == '0) ? S_DONE : S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  if (w_wait_end) w_next = S_EXEC;
      S_EXEC: begin
        if (w_ex_err != E_NONE) w_next = S_DONE;
        else if (w_last)        w_next = S_FINAL;
        else                    w_next = S_FETCH;
      end
      S_FINAL: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control counters, stack pointer and result/error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_tok      <= '0;
      r_sp       <= '0;
      r_result   <= '0;
      r_error    <= 1'b0;
      r_err_code <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= token_count;
            r_idx    <= '0;
            r_wcnt   <= '0;
            r_sp     <= '0;
            r_result <= '0;
            if (token_count == '0) begin
              r_error    <= 1'b1;
              r_err_code <= E_DEPTH;
            end else begin
              r_error    <= 1'b0;
              r_err_code <= E_NONE;
            end
          end
        end
        S_FETCH: r_wcnt <= '0;
        S_WAIT: begin
          r_wcnt <= r_wcnt + 2'd1;
          if (w_wait_end) r_tok <= rd_data;
        end
        S_EXEC: begin
          if (w_ex_err != E_NONE) begin
            r_error    <= 1'b1;
            r_err_code <= w_ex_err;
          end else begin
            r_idx <= w_idx_nx;
            if (!w_is_op) r_sp <= r_sp + SPW'(1);
            else          r_sp <= r_sp - SPW'(1);
          end
        end
        S_FINAL: begin
          if (r_sp == SPW'(1)) begin
            r_result <= w_b;
          end else begin
            r_error    <= 1'b1;
            r_err_code <= E_DEPTH;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand stack storage (contents are not reset)
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_EXEC && w_ex_err == E_NONE) begin
      if (!w_is_op) r_stk[w_pi] <= w_operand;
      else          r_stk[w_si] <= w_alu;
    end
  end

  assign rd_en    = (r_state == S_FETCH);
  assign rd_addr  = r_idx;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign error    = r_error;
  assign err_code = r_err_code;

endmodule
